// File: rtl/instruction_memory_if.sv
// instruction_memory_if
//   Fetch and programming bus between the CPU front end and the instruction
//   store.
//   master : fetch stage / program loader (drives pc and prog_*)
//   slave  : instruction_memory (returns instruction, addr_fault, prog_err)
//   pc          word address to fetch
//   instruction word at pc (combinational)
//   addr_fault  pc lies beyond the implemented store
//   prog_we     programming write enable
//   prog_addr   programming word address
//   prog_data   word to store
//   prog_err    one-cycle flag: the previous write targeted a missing address
interface instruction_memory_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instruction;
    logic                  addr_fault;
    logic                  prog_we;
    logic [ADDR_WIDTH-1:0] prog_addr;
    logic [DATA_WIDTH-1:0] prog_data;
    logic                  prog_err;

    modport master (
        output pc, prog_we, prog_addr, prog_data,
        input  instruction, addr_fault, prog_err
    );

    modport slave (
        input  pc, prog_we, prog_addr, prog_data,
        output instruction, addr_fault, prog_err
    );
endinterface

// File: rtl/instruction_memory.sv
// instruction_memory
//   Word-addressed instruction store for the 16-bit CPU. Fetch is purely
//   combinational in pc; the programming port writes one word per rising
//   clock edge. An asynchronous reset clears every word to NOP (0).
//   clk  single clock, writes on its rising edge
//   rst  asynchronous active-high reset; also blocks writes while high
//   bus  instruction_memory_if slave: pc/instruction/addr_fault fetch side,
//        prog_we/prog_addr/prog_data/prog_err programming side
module instruction_memory #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    instruction_memory_if.slave  bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH itself is representable when DEPTH == 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    // Storage is built from flops rather than a RAM macro: the whole array
    // must clear asynchronously on reset.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  prog_err_q;
    logic                  prog_err_d;

    logic                  pc_in_range;
    logic                  wr_in_range;
    logic [IDX_W-1:0]      pc_idx;
    logic [IDX_W-1:0]      wr_idx;

    assign pc_in_range = ({1'b0, bus.pc} < DEPTH_W);
    assign wr_in_range = ({1'b0, bus.prog_addr} < DEPTH_W);
    assign pc_idx      = bus.pc[IDX_W-1:0];
    assign wr_idx      = bus.prog_addr[IDX_W-1:0];

    // Fetch: out-of-range pc returns NOP instead of an aliased word.
    assign bus.addr_fault  = ~pc_in_range;
    assign bus.instruction = pc_in_range ? mem_q[pc_idx] : '0;

    // Flag rejected writes; any other cycle (idle or good write) clears it.
    assign prog_err_d = bus.prog_we & ~wr_in_range;
    assign bus.prog_err = prog_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            prog_err_q <= 1'b0;
        end else begin
            prog_err_q <= prog_err_d;
            if (bus.prog_we && wr_in_range) begin
                mem_q[wr_idx] <= bus.prog_data;
            end
        end
    end
endmodule

// File: tb/tb_instruction_memory.sv
module tb_instruction_memory;
    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instruction_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    instruction_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Reference: a plain array of words plus the expected error flag.
    logic [DW-1:0] ref_mem [DEPTH];
    logic          ref_err;
    int vectors     = 0;
    int miscompares = 0;

    function automatic logic [DW-1:0] exp_instr(input logic [AW-1:0] a);
        if (int'(a) < DEPTH) return ref_mem[int'(a)];
        return '0;
    endfunction

    function automatic logic exp_fault(input logic [AW-1:0] a);
        return int'(a) >= DEPTH;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        ref_err = 1'b0;
    endtask

    // One programming cycle: drive at negedge, edge, update model, release.
    // Returns at posedge + 1.
    task automatic write_cycle(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        bus.prog_we   = 1'b1;
        bus.prog_addr = a;
        bus.prog_data = d;
        @(posedge clk);
        if (!rst) begin
            if (int'(a) < DEPTH) ref_mem[int'(a)] = d;
            ref_err = (int'(a) >= DEPTH);
        end else begin
            ref_err = 1'b0;
        end
        #1;
        bus.prog_we = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        if (!rst) ref_err = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.pc = 16'd10;
        bus.prog_we = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (bus.instruction !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_instr: got %h want 0000", bus.instruction);
        end
        vectors++;
        if (bus.addr_fault !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_fault: got %b want 0", bus.addr_fault);
        end
        vectors++;
        if (bus.prog_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_err: got %b want 0", bus.prog_err);
        end
    endtask

    task automatic test_single_write();
        write_cycle(16'd10, 16'hA5C3);
        bus.pc = 16'd10;
        #1;
        vectors++;
        if (bus.instruction !== 16'hA5C3) begin
            miscompares++;
            $display("FAIL single_pc10: got %h want a5c3", bus.instruction);
        end
        bus.pc = 16'd11;
        #1;
        vectors++;
        if (bus.instruction !== 16'h0000) begin
            miscompares++;
            $display("FAIL single_pc11: got %h want 0000", bus.instruction);
        end
    endtask

    task automatic test_sweep();
        for (int a = 0; a < DEPTH; a++) write_cycle(AW'(a), DW'(a) ^ 16'h5A5A);
        for (int a = 0; a <= DEPTH; a++) begin
            bus.pc = AW'(a);
            #1;
            vectors++;
            if (bus.instruction !== exp_instr(bus.pc) || bus.addr_fault !== exp_fault(bus.pc)) begin
                miscompares++;
                $display("FAIL sweep pc=%0d: got %h/%b want %h/%b", a, bus.instruction,
                         bus.addr_fault, exp_instr(bus.pc), exp_fault(bus.pc));
            end
        end
    endtask

    task automatic test_out_of_range();
        write_cycle(16'd300, 16'hFFFF);
        vectors++;
        if (bus.prog_err !== 1'b1) begin
            miscompares++;
            $display("FAIL oor_err_set: got %b want 1", bus.prog_err);
        end
        idle_cycle();
        vectors++;
        if (bus.prog_err !== 1'b0) begin
            miscompares++;
            $display("FAIL oor_err_clear: got %b want 0", bus.prog_err);
        end
        bus.pc = 16'd300;
        #1;
        vectors++;
        if (bus.instruction !== 16'h0000 || bus.addr_fault !== 1'b1) begin
            miscompares++;
            $display("FAIL oor_pc300: got %h/%b want 0000/1", bus.instruction, bus.addr_fault);
        end
        for (int a = 0; a < DEPTH; a++) begin
            bus.pc = AW'(a);
            #1;
            vectors++;
            if (bus.instruction !== exp_instr(bus.pc)) begin
                miscompares++;
                $display("FAIL oor_untouched pc=%0d: got %h want %h", a, bus.instruction, exp_instr(bus.pc));
            end
        end
    endtask

    task automatic test_write_fetch_same();
        logic [DW-1:0] old_w;
        old_w = ref_mem[5];
        bus.pc = 16'd5;
        @(negedge clk);
        bus.prog_we = 1'b1;
        bus.prog_addr = 16'd5;
        bus.prog_data = 16'h1234;
        #1;
        vectors++;
        if (bus.instruction !== old_w) begin
            miscompares++;
            $display("FAIL same_before: got %h want %h", bus.instruction, old_w);
        end
        @(posedge clk);
        ref_mem[5] = 16'h1234;
        ref_err = 1'b0;
        #1;
        bus.prog_we = 1'b0;
        vectors++;
        if (bus.instruction !== 16'h1234) begin
            miscompares++;
            $display("FAIL same_after: got %h want 1234", bus.instruction);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d;
        // Same address three edges in a row: last write wins.
        write_cycle(16'd40, 16'h1111);
        write_cycle(16'd40, 16'h2222);
        write_cycle(16'd40, 16'h3333);
        bus.pc = 16'd40;
        #1;
        vectors++;
        if (bus.instruction !== 16'h3333) begin
            miscompares++;
            $display("FAIL b2b_last_wins: got %h want 3333", bus.instruction);
        end
        // Error flag tracks each edge independently.
        for (int i = 0; i < 12; i++) begin
            logic [AW-1:0] a;
            a = (i % 3 == 1) ? AW'(256 + i) : AW'(i * 7);
            d = DW'($urandom);
            write_cycle(a, d);
            vectors++;
            if (bus.prog_err !== ref_err) begin
                miscompares++;
                $display("FAIL b2b_err i=%0d: got %b want %b", i, bus.prog_err, ref_err);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            logic [AW-1:0] a;
            if ($urandom_range(0, 3) != 0) begin
                a = ($urandom_range(0, 4) == 0) ? AW'($urandom) : AW'($urandom_range(0, 399));
                write_cycle(a, DW'($urandom));
                vectors++;
                if (bus.prog_err !== ref_err) begin
                    miscompares++;
                    $display("FAIL rand_err i=%0d addr=%0d: got %b want %b", i, a, bus.prog_err, ref_err);
                end
            end else begin
                idle_cycle();
            end
            bus.pc = ($urandom_range(0, 5) == 0) ? AW'($urandom) : AW'($urandom_range(0, 270));
            #1;
            vectors++;
            if (bus.instruction !== exp_instr(bus.pc) || bus.addr_fault !== exp_fault(bus.pc)) begin
                miscompares++;
                $display("FAIL rand_fetch pc=%0d: got %h/%b want %h/%b", bus.pc, bus.instruction,
                         bus.addr_fault, exp_instr(bus.pc), exp_fault(bus.pc));
            end
        end
    endtask

    task automatic test_async_reset();
        write_cycle(16'd20, 16'h7E7E);
        bus.pc = 16'd20;
        #1;
        vectors++;
        if (bus.instruction !== 16'h7E7E) begin
            miscompares++;
            $display("FAIL ares_preload: got %h want 7e7e", bus.instruction);
        end
        // Assert reset between edges; store must clear with no clock edge.
        @(negedge clk);
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        for (int a = 0; a < DEPTH; a += 5) begin
            bus.pc = AW'(a);
            #0.1;
            vectors++;
            if (bus.instruction !== 16'h0000) begin
                miscompares++;
                $display("FAIL ares_clear pc=%0d: got %h want 0000", a, bus.instruction);
            end
        end
        write_cycle(16'd20, 16'hBEEF);
        bus.pc = 16'd20;
        #1;
        vectors++;
        if (bus.instruction !== 16'h0000 || bus.prog_err !== 1'b0) begin
            miscompares++;
            $display("FAIL ares_write_blocked: got %h/%b want 0000/0", bus.instruction, bus.prog_err);
        end
        @(negedge clk);
        rst = 1'b0;
        write_cycle(16'd20, 16'hBEEF);
        vectors++;
        if (bus.instruction !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL ares_first_write: got %h want beef", bus.instruction);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_sweep();
        test_out_of_range();
        test_write_fetch_same();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
